// File: rtl/palindrome_stream_detector_if.sv
// Symbol stream and result handshake bundle for palindrome_stream_detector.
// The source/sink side uses the master modport; the detector uses slave.
interface palindrome_stream_detector_if #(
  parameter int SYM_W = 1
);
  logic             i_valid;
  logic             o_ready;
  logic [SYM_W-1:0] i_data;
  logic             i_mode;
  logic             o_valid;
  logic             i_ready;
  logic             o_match;

  modport master (
    output i_valid, i_data, i_mode, i_ready,
    input  o_ready, o_valid, o_match
  );

  modport slave (
    input  i_valid, i_data, i_mode, i_ready,
    output o_ready, o_valid, o_match
  );
endinterface

// File: rtl/palindrome_stream_detector.sv
// Streaming palindrome detector over the last WIN_LEN accepted symbols.
// Each accept shifts the window (win_r[0] newest); once the window is full,
// every accept loads one result into a single output register with
// backpressure. Mode 0 compares symbol order, mode 1 compares the fully
// bit-reversed flattened window. A saturating counter tallies matches.
module palindrome_stream_detector #(
  parameter int SYM_W   = 1,
  parameter int WIN_LEN = 4,
  parameter int CNT_W   = 16,
  localparam int FILL_W = $clog2(WIN_LEN + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_clear,
  palindrome_stream_detector_if.slave   bus,
  output logic [FILL_W-1:0]             o_fill,
  output logic [CNT_W-1:0]              o_match_cnt
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIN_LEN);
  localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [SYM_W-1:0]  win_r    [WIN_LEN];
  logic [SYM_W-1:0]  win_next [WIN_LEN];
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_next;
  logic              valid_r;
  logic              match_r;
  logic [CNT_W-1:0]  cnt_r;

  logic              ready_s;
  logic              accept_s;
  logic              load_s;
  logic              sym_match_s;
  logic              bit_match_s;
  logic              match_s;

  // Mirror a symbol end to end (bit 0 <-> bit SYM_W-1).
  function automatic logic [SYM_W-1:0] bit_reverse(input logic [SYM_W-1:0] v);
    logic [SYM_W-1:0] r;
    r = {SYM_W{1'b0}};
    for (int b = 0; b < SYM_W; b++) begin
      r[b] = v[SYM_W-1-b];
    end
    return r;
  endfunction

  // Handshake: accept only when not flushing and the output slot is free or draining.
  always_comb begin
    ready_s  = !i_clear && (!valid_r || bus.i_ready);
    accept_s = bus.i_valid && ready_s;
  end

  // Post-shift window and fill as they will look after this accept.
  always_comb begin
    win_next[0] = bus.i_data;
    for (int k = 1; k < WIN_LEN; k++) begin
      win_next[k] = win_r[k-1];
    end
    fill_next = (fill_r == FILL_FULL) ? fill_r : (fill_r + FILL_ONE);
    load_s    = accept_s && (fill_next == FILL_FULL);
  end

  // Palindrome evaluation of the post-shift window in both modes.
  always_comb begin
    sym_match_s = 1'b1;
    bit_match_s = 1'b1;
    for (int k = 0; k < WIN_LEN; k++) begin
      sym_match_s = sym_match_s & (win_next[k] == win_next[WIN_LEN-1-k]);
      bit_match_s = bit_match_s & (win_next[k] == bit_reverse(win_next[WIN_LEN-1-k]));
    end
    match_s = bus.i_mode ? bit_match_s : sym_match_s;
  end

  // Window shift register and saturating fill count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      win_r  <= '{default: {SYM_W{1'b0}}};
      fill_r <= {FILL_W{1'b0}};
    end else if (i_clear) begin
      win_r  <= '{default: {SYM_W{1'b0}}};
      fill_r <= {FILL_W{1'b0}};
    end else if (accept_s) begin
      win_r  <= win_next;
      fill_r <= fill_next;
    end else begin
      win_r  <= win_r;
      fill_r <= fill_r;
    end
  end

  // Output result register: load on eligible accept, drop on drain, hold under backpressure.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_r <= 1'b0;
      match_r <= 1'b0;
    end else if (i_clear) begin
      valid_r <= 1'b0;
      match_r <= 1'b0;
    end else if (load_s) begin
      valid_r <= 1'b1;
      match_r <= match_s;
    end else if (bus.i_ready) begin
      valid_r <= 1'b0;
      match_r <= match_r;
    end else begin
      valid_r <= valid_r;
      match_r <= match_r;
    end
  end

  // Saturating count of loaded results that matched.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load_s && match_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bus.o_ready  = ready_s;
  assign bus.o_valid  = valid_r;
  assign bus.o_match  = match_r;
  assign o_fill       = fill_r;
  assign o_match_cnt  = cnt_r;

endmodule

// File: tb/tb_palindrome_stream_detector.sv
// Scoreboard bench for palindrome_stream_detector (SYM_W=2, WIN_LEN=3, CNT_W=2).
// A reference model tracks the accepted-symbol history as a queue and judges
// palindromes by reversing symbol lists / flattened bit lists; expected
// results are queued and a monitor compares them as the DUT presents them.
module tb_palindrome_stream_detector;

  localparam int SW   = 2;
  localparam int WL   = 3;
  localparam int CW   = 2;
  localparam int FW   = $clog2(WL + 1);
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [SW-1:0] sym_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          clear = 1'b0;
  logic [FW-1:0] o_fill;
  logic [CW-1:0] o_match_cnt;

  palindrome_stream_detector_if #(.SYM_W(SW)) bus ();

  palindrome_stream_detector #(
    .SYM_W  (SW),
    .WIN_LEN(WL),
    .CNT_W  (CW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .bus        (bus),
    .o_fill     (o_fill),
    .o_match_cnt(o_match_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state
  sym_t m_win[$];          // accepted symbols, newest first, at most WL
  bit   m_valid = 1'b0;
  int   m_cnt   = 0;
  bit   exp_q[$];          // expected o_match values, oldest first
  bit   done    = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;

  function automatic bit is_pal(input sym_t w[$], input bit bit_mode);
    sym_t rev[$];
    bit   bits[$];
    if (!bit_mode) begin
      for (int k = w.size() - 1; k >= 0; k--) rev.push_back(w[k]);
      for (int k = 0; k < w.size(); k++) if (rev[k] !== w[k]) return 1'b0;
      return 1'b1;
    end
    // flatten oldest symbol first, MSB first, then compare with its reverse
    for (int k = w.size() - 1; k >= 0; k--)
      for (int b = SW - 1; b >= 0; b--) bits.push_back(w[k][b]);
    for (int i = 0; i < bits.size(); i++)
      if (bits[i] != bits[bits.size() - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: updates on each clock edge or asynchronous reset
  initial begin
    bit acc;
    bit r;
    forever begin
      @(posedge clk or posedge rst);
      if (rst || clear) begin
        m_win.delete();
        m_valid = 1'b0;
        m_cnt   = 0;
        exp_q.delete();
      end else begin
        acc = bus.i_valid && (!m_valid || bus.i_ready);
        if (acc) begin
          m_win.push_front(bus.i_data);
          if (m_win.size() > WL) void'(m_win.pop_back());
        end
        if (acc && m_win.size() == WL) begin
          r = is_pal(m_win, bus.i_mode);
          exp_q.push_back(r);
          m_valid = 1'b1;
          if (r && m_cnt < CMAX) m_cnt++;
        end else if (m_valid && bus.i_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against the model on every falling edge
  initial begin
    int cyc;
    cyc = 0;
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      chk("o_ready", int'(bus.o_ready), int'(!clear && (!m_valid || bus.i_ready)));
      chk("o_valid", int'(bus.o_valid), int'(m_valid));
      chk("o_fill", int'(o_fill), m_win.size());
      chk("o_match_cnt", int'(o_match_cnt), m_cnt);
      if (bus.o_valid) begin
        chk("result_pending", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("o_match", int'(bus.o_match), int'(exp_q[0]));
          if (bus.i_ready) void'(exp_q.pop_front());
        end
      end
    end
    chk("finished_in_time", int'(done), 1);
    chk("leftover_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  task automatic push(input sym_t d, input bit m, input bit rdy_after);
    bit ok;
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_mode  = m;
    bus.i_ready = 1'b1;
    clear       = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = bus.o_ready;
    end
    if (!ok) begin
      $display("FAIL push_accept: got o_ready 0 expected 1 at %0t", $time);
      $fatal(1, "symbol never accepted");
    end
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    bus.i_ready = rdy_after;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1;
    clear       = 1'b1;
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    clear       = 1'b0;
  endtask

  // Stimulus: directed scenarios, then randomized traffic
  initial begin
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_mode  = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // bit mode, odd window: 01,11,10 matches; 01,01,10 does not
    push(2'b01, 1'b1, 1'b1); push(2'b11, 1'b1, 1'b1); push(2'b10, 1'b1, 1'b1);
    pulse_clear();
    push(2'b01, 1'b1, 1'b1); push(2'b01, 1'b1, 1'b1); push(2'b10, 1'b1, 1'b1);
    pulse_clear();

    // symbol mode, then backpressure with a waiting symbol
    push(2'b01, 1'b0, 1'b1); push(2'b10, 1'b0, 1'b1); push(2'b01, 1'b0, 1'b1);
    push(2'b10, 1'b0, 1'b0);
    bus.i_valid = 1'b1;
    bus.i_data  = 2'b11;
    bus.i_mode  = 1'b0;
    repeat (5) @(posedge clk);
    #1 bus.i_ready = 1'b1;
    @(posedge clk); #1 bus.i_valid = 1'b0;
    pulse_clear();

    // counter saturation with all-zero symbols
    for (int i = 0; i < 6; i++) push(2'b00, 1'b0, 1'b1);

    // clear together with a valid symbol at full window
    @(posedge clk); #1;
    clear       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 2'b11;
    @(posedge clk); #1;
    clear       = 1'b0;
    bus.i_valid = 1'b0;

    // asynchronous reset mid-cycle at fill 2, then a fresh stream
    push(2'b01, 1'b0, 1'b1); push(2'b10, 1'b0, 1'b1);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    push(2'b11, 1'b1, 1'b1); push(2'b00, 1'b1, 1'b1); push(2'b11, 1'b1, 1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst         = 1'b0;
      bus.i_valid = ($urandom % 4) != 0;
      bus.i_data  = sym_t'($urandom);
      bus.i_mode  = 1'($urandom);
      bus.i_ready = ($urandom % 10) < 7;
      clear       = ($urandom % 40) == 0;
      if (($urandom % 300) == 0) begin
        #2 rst = 1'b1;
      end
    end

    @(posedge clk); #1;
    rst         = 1'b0;
    clear       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    repeat (5) @(posedge clk);
    done = 1'b1;
  end

endmodule

// File: doc/palindrome_stream_detector.md
Name: palindrome_stream_detector

Overview:
- Streaming, parametrised palindrome detector over a sliding window of the last WIN_LEN accepted symbols, each SYM_W bits wide.
- Supports two comparison modes: symbol-order reversal, and full bit reversal of the flattened window.
- Valid/ready on both sides, one registered output stage with backpressure, and a saturating match counter.
- Sits after a symbol source (deserialiser or FIFO) and feeds match flags to a pattern-statistics consumer.

Parameters:
- SYM_W, 1, bits per symbol (>=1).
- WIN_LEN, 4, window length in symbols (>=2).
- CNT_W, 16, width of the saturating match counter (>=1).

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_clear  input  1  synchronous flush of window, fill count, output stage and counter.
- i_valid  input  1  input symbol valid.
- o_ready  output  1  block can accept a symbol.
- i_data  input  SYM_W  input symbol.
- i_mode  input  1  0 = symbol mode, 1 = bit mode; sampled with each accepted symbol.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_match  output  1  1 = window was a palindrome under the sampled mode.
- o_fill  output  clog2(WIN_LEN+1)  symbols currently in the window, saturating at WIN_LEN.
- o_match_cnt  output  CNT_W  count of match results loaded, saturating.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - window cleared to 0; o_fill=0; o_valid=0; o_match=0; o_match_cnt=0.
  - o_ready is combinational and therefore follows the flush state.
- o_ready = !i_clear && (!o_valid || i_ready).
- A symbol is accepted when i_valid && o_ready.
- Window update on accept:
  - win[0] is the newest symbol; win[k] <= win[k-1]; win[0] <= i_data.
  - The oldest symbol falls off the end.
- o_fill increments on each accept until it reaches WIN_LEN, then holds.
- Evaluation uses the post-shift window, computed combinationally and registered on the same edge as the accept (latency 1 cycle from the accept edge to o_valid).
- A result is produced only for accepts where the post-shift fill equals WIN_LEN, i.e. from the WIN_LEN-th accepted symbol onward. Earlier accepts produce no o_valid.
- Symbol mode: match iff win[k] == win[WIN_LEN-1-k] for every k.
- Bit mode: match iff win[k] == bitrev(win[WIN_LEN-1-k]) for every k. This is equivalent to the flattened vector {win[WIN_LEN-1]..win[0]} equalling its own bit reverse.
  - For odd WIN_LEN in bit mode, the middle symbol must equal its own bit reverse.
  - With SYM_W=1, the two modes give identical results.
- Output register:
  - Loaded when an eligible accept occurs; the accept is only possible if the register is empty or being drained in the same cycle.
  - If i_ready=1 with no new load, o_valid drops to 0.
  - While o_valid=1 && i_ready=0, o_valid and o_match hold stable and no symbol is accepted.
- o_match_cnt increments by 1 on each load with match=1 and saturates at 2^CNT_W-1 (no wrap).
- i_clear=1:
  - Next edge: window=0, o_fill=0, o_valid=0, o_match=0, o_match_cnt=0.
  - o_ready=0 in the clear cycle, so a concurrent i_valid symbol is not accepted and the source must hold it.
  - Clear overrides a pending unconsumed result, which is discarded.
- i_rst asserted mid-stream: all state returns to reset values immediately; a partially filled window is lost and the stream restarts from fill 0.
- i_mode changing between symbols is legal; each result uses the mode sampled with its own triggering symbol.
- No X propagation: i_data and i_mode are ignored when not accepted.

Test Plan:
- SYM_W=1, WIN_LEN=4, mode 0; accept 1,0,0,1,0 (i_ready=1) -> no o_valid for the first three accepts; results 1 then 0; o_fill=1,2,3,4,4; o_match_cnt=1.
- SYM_W=4, WIN_LEN=4; accept A,B,B,A with mode 0 -> match=1. Same stream with mode 1 -> match=0. Stream 9,6,6,9 with mode 1 -> match=1.
- Backpressure: i_ready=0 after the first result -> o_valid/o_match hold for 5 cycles, o_ready=0, and an i_valid symbol is held by the source. Release i_ready -> symbol accepted in that cycle, next result one cycle later, nothing lost or duplicated.
- WIN_LEN=3, SYM_W=2, mode 1; stream 2'b01,2'b11,2'b10 -> match=1. Stream 2'b01,2'b01,2'b10 -> match=0 (middle 01 is not self-reversed).
- CNT_W=2; feed 5 consecutive matching windows (all-zero symbols) -> o_match_cnt goes 1,2,3,3,3.
- i_clear together with i_valid at fill=3 -> symbol not accepted, fill=0, count=0. Assert i_rst at fill=2 mid-cycle -> outputs zero immediately; after release, WIN_LEN fresh symbols are needed before the first o_valid.
